// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Prescaled 8-LED pattern generator (rotate/bounce/count/blink)
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer #(
  parameter int DIV = 1_200_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       step,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       LED6,
  output logic       LED7
);

  localparam int          CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(DIV - 1);

  localparam logic [1:0] c_shift  = 2'd0;
  localparam logic [1:0] c_bounce = 2'd1;
  localparam logic [1:0] c_count  = 2'd2;
  localparam logic [1:0] c_blink  = 2'd3;

  typedef enum logic [0:0] {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_pat;
  logic [7:0]    w_pat_nxt;
  logic [1:0]    r_mode;
  dir_t          r_dir;
  dir_t          w_dir_nxt;
  logic          w_step;

  // Gated by en so a step can never fire while frozen.
  assign w_step = en && (r_cnt == c_last);
  assign step   = w_step;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == c_last) r_cnt <= '0;
      else                 r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat  <= 8'h01;
      r_mode <= c_shift;
      r_dir  <= UP;
    end else if (w_step) begin
      r_pat  <= w_pat_nxt;
      r_mode <= mode;
      r_dir  <= w_dir_nxt;
    end
  end

  always_comb begin
    w_pat_nxt = r_pat;
    w_dir_nxt = r_dir;
    if (mode != r_mode) begin
      // A mode switch only loads the start value; advancing resumes next step.
      w_dir_nxt = UP;
      case (mode)
        c_shift:  w_pat_nxt = 8'h01;
        c_bounce: w_pat_nxt = 8'h01;
        c_count:  w_pat_nxt = 8'h00;
        default:  w_pat_nxt = 8'hFF;
      endcase
    end else begin
      case (r_mode)
        c_shift:  w_pat_nxt = {r_pat[6:0], r_pat[7]};
        c_bounce: begin
          case (r_dir)
            UP: begin
              if (r_pat == 8'h80) begin
                w_pat_nxt = 8'h40;
                w_dir_nxt = DOWN;
              end else begin
                w_pat_nxt = r_pat << 1;
              end
            end
            default: begin
              if (r_pat == 8'h01) begin
                w_pat_nxt = 8'h02;
                w_dir_nxt = UP;
              end else begin
                w_pat_nxt = r_pat >> 1;
              end
            end
          endcase
        end
        c_count:  w_pat_nxt = r_pat + 8'd1;
        default:  w_pat_nxt = ~r_pat;
      endcase
    end
  end

  assign LED0 = r_pat[0];
  assign LED1 = r_pat[1];
  assign LED2 = r_pat[2];
  assign LED3 = r_pat[3];
  assign LED4 = r_pat[4];
  assign LED5 = r_pat[5];
  assign LED6 = r_pat[6];
  assign LED7 = r_pat[7];

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sequencer
// Description : Scoreboard bench for led_sequencer (DIV=4, 10 ns clock)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  localparam int c_div = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       en   = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       step;
  logic       LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] w_leds;

  logic [7:0] r_exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         gap    = 0;

  led_sequencer #(.DIV(c_div)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .mode (mode),
    .step (step),
    .LED0 (LED0),
    .LED1 (LED1),
    .LED2 (LED2),
    .LED3 (LED3),
    .LED4 (LED4),
    .LED5 (LED5),
    .LED6 (LED6),
    .LED7 (LED7)
  );

  always #5 clk = ~clk;

  assign w_leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push(input logic [7:0] v);
    r_exp_q.push_back(v);
  endtask

  // Blocks until the monitor has consumed every queued pattern; returns at posedge+2.
  task automatic drain();
    int n;
    n = 0;
    while (r_exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (r_exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d patterns pending, expected 0", r_exp_q.size());
      r_exp_q.delete();
    end
  endtask

  // Monitor: every step pulse must be DIV enabled cycles after the previous
  // one, and the LEDs one edge later must match the next queued pattern.
  always @(negedge clk) begin
    if (!rstn) begin
      gap = 0;
    end else begin
      if (en) gap++;
      if (step) begin
        check("step_gap", gap, c_div);
        gap = 0;
        @(posedge clk);
        #1;
        if (r_exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_step: leds=%0h, expected no step", w_leds);
        end else begin
          check("pattern", w_leds, r_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #12;
    check("reset_leds", w_leds, 8'h01);
    check("reset_step", step, 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    en   = 1'b1;

    // Run to 8'h10, then reset asynchronously in a cycle where step is high.
    push(8'h02); push(8'h04); push(8'h08); push(8'h10);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_step", step, 1);
    check("pre_reset_leds", w_leds, 8'h10);
    #1;
    rstn = 1'b0;
    #1;
    check("async_reset_leds", w_leds, 8'h01);
    check("async_reset_step", step, 0);
    @(posedge clk); #2;
    rstn = 1'b1;

    // SHIFT: full rotation and wrap.
    push(8'h02); push(8'h04); push(8'h08); push(8'h10);
    push(8'h20); push(8'h40); push(8'h80); push(8'h01); push(8'h02);
    drain();

    // BOUNCE: load then 15 advances.
    mode = 2'd1;
    push(8'h01);
    push(8'h02); push(8'h04); push(8'h08); push(8'h10); push(8'h20);
    push(8'h40); push(8'h80); push(8'h40); push(8'h20); push(8'h10);
    push(8'h08); push(8'h04); push(8'h02); push(8'h01); push(8'h02);
    drain();

    // COUNT: load 00, count through FF and wrap to 00.
    mode = 2'd2;
    push(8'h00);
    for (int i = 1; i <= 256; i++) push(8'(i));
    drain();

    // BLINK, then freeze mid-count for 20 cycles.
    mode = 2'd3;
    push(8'hFF); push(8'h00);
    drain();
    @(posedge clk); #2;
    en = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("freeze_step", step, 0);
      check("freeze_leds", w_leds, 8'h00);
    end
    @(posedge clk); #2;
    en = 1'b1;
    push(8'hFF);
    drain();

    // Mode glitch between steps is ignored.
    mode = 2'd0;
    push(8'h01);
    drain();
    @(posedge clk); #2;
    mode = 2'd2;
    @(posedge clk); #2;
    mode = 2'd0;
    push(8'h02); push(8'h04);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
